aes_trace_sequencer: RTL and testbench

Synthesizable, parametrised stimulus sequencer for `AES_top` power/timing trace campaigns. It drives the AES core with a programmable number of encryptions under a fixed key, with plaintexts generated from a seed. For each trace it holds `AES_en` for a fixed window, raises a scope trigger, captures the first ciphertext, enforces a timeout and inserts an idle gap. It sits between a host/UART register block and `AES_top`, and replaces hand-written per-vector benches.

---
 rtl/aes_trace_sequencer_if.sv | 33 +++
 rtl/aes_trace_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_aes_trace_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_trace_sequencer_if.sv
// Campaign control, AES_top drive/return and trace-capture signals of aes_trace_sequencer.
// master = sequencer side, slave = host / AES_top side.
interface aes_trace_sequencer_if #(
  parameter int IDX_W = 16
);
  logic               seq_start;
  logic [127:0]       seq_key;
  logic [127:0]       seq_seed;
  logic               aes_en;
  logic [127:0]       aes_data_in;
  logic [127:0]       aes_key_in;
  logic               aes_data_out_valid;
  logic [127:0]       aes_data_out;
  logic               trig;
  logic               ct_valid;
  logic [127:0]       ct_data;
  logic [IDX_W-1:0]   ct_index;
  logic               seq_busy;
  logic               seq_done;
  logic               seq_timeout;

  modport master (
    input  seq_start, seq_key, seq_seed, aes_data_out_valid, aes_data_out,
    output aes_en, aes_data_in, aes_key_in, trig, ct_valid, ct_data, ct_index,
           seq_busy, seq_done, seq_timeout
  );

  modport slave (
    output seq_start, seq_key, seq_seed, aes_data_out_valid, aes_data_out,
    input  aes_en, aes_data_in, aes_key_in, trig, ct_valid, ct_data, ct_index,
           seq_busy, seq_done, seq_timeout
  );
endinterface

// File: rtl/aes_trace_sequencer.sv
// Trace-campaign sequencer for AES_top: fixed key, seeded plaintexts, first-ciphertext capture.
// Define AES_TRACE_LFSR_EN to step plaintexts with a 128-bit Galois LFSR instead of +1.
module aes_trace_sequencer #(
  parameter int NUM_TRACES     = 166,
  parameter int EN_CYCLES      = 51,
  parameter int GAP_CYCLES     = 15,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDX_W          = 16
) (
  input  logic                  AES_clk,
  input  logic                  AES_rst,
  aes_trace_sequencer_if.master bus
);
  localparam int GAP_LEN = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int EN_W    = $clog2(EN_CYCLES + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W   = $clog2(GAP_LEN + 1);

  localparam logic [EN_W-1:0]  EN_LAST  = EN_W'(EN_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TRACES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  function automatic logic [127:0] next_pt(input logic [127:0] pt);
`ifdef AES_TRACE_LFSR_EN
    next_pt = {pt[126:0], 1'b0} ^ {120'd0, (pt[127] ? 8'h87 : 8'h00)};
`else
    next_pt = pt + 128'd1;
`endif
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed is bumped to 1.
  function automatic logic [127:0] seed_fix(input logic [127:0] seed);
`ifdef AES_TRACE_LFSR_EN
    seed_fix = (seed == 128'd0) ? 128'd1 : seed;
`else
    seed_fix = seed;
`endif
  endfunction

  state_e             state_q,     state_d;
  logic [EN_W-1:0]    en_cnt_q,    en_cnt_d;
  logic [TO_W-1:0]    to_cnt_q,    to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic               captured_q,  captured_d;
  logic               aes_en_q,    aes_en_d;
  logic [127:0]       pt_q,        pt_d;
  logic [127:0]       key_q,       key_d;
  logic               ct_valid_q,  ct_valid_d;
  logic [127:0]       ct_data_q,   ct_data_d;
  logic [IDX_W-1:0]   ct_index_q,  ct_index_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic               timeout_q,   timeout_d;

  logic               cap_now_s;
  logic               last_trace_s;
  state_e             end_state_s;

  // State and output registers
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state_q    <= ST_IDLE;
      en_cnt_q   <= '0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
      captured_q <= 1'b0;
      aes_en_q   <= 1'b0;
      pt_q       <= 128'd0;
      key_q      <= 128'd0;
      ct_valid_q <= 1'b0;
      ct_data_q  <= 128'd0;
      ct_index_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_cnt_q   <= en_cnt_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
      captured_q <= captured_d;
      aes_en_q   <= aes_en_d;
      pt_q       <= pt_d;
      key_q      <= key_d;
      ct_valid_q <= ct_valid_d;
      ct_data_q  <= ct_data_d;
      ct_index_q <= ct_index_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state, capture and output decode
  always_comb begin
    state_d    = state_q;
    en_cnt_d   = en_cnt_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    captured_d = captured_q;
    aes_en_d   = aes_en_q;
    pt_d       = pt_q;
    key_d      = key_q;
    ct_valid_d = 1'b0;
    ct_data_d  = ct_data_q;
    ct_index_d = ct_index_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;

    cap_now_s    = bus.aes_data_out_valid && !captured_q &&
                   ((state_q == ST_RUN) || (state_q == ST_WAIT));
    last_trace_s = (idx_q == IDX_LAST);
    end_state_s  = last_trace_s ? ST_IDLE : ST_GAP;

    if (cap_now_s) begin
      captured_d = 1'b1;
      ct_valid_d = 1'b1;
      ct_data_d  = bus.aes_data_out;
      ct_index_d = idx_q;
    end else begin
      captured_d = captured_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.seq_start) begin
          state_d    = ST_RUN;
          key_d      = bus.seq_key;
          pt_d       = seed_fix(bus.seq_seed);
          idx_d      = '0;
          en_cnt_d   = '0;
          to_cnt_d   = '0;
          captured_d = 1'b0;
          aes_en_d   = 1'b1;
          timeout_d  = 1'b0;
        end else begin
          aes_en_d   = 1'b0;
        end
      end
      ST_RUN: begin
        en_cnt_d = en_cnt_q + EN_W'(1);
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (en_cnt_q == EN_LAST) begin
          aes_en_d = 1'b0;
          // A ciphertext arriving on the very last enable cycle still counts as in time.
          if (captured_q || cap_now_s) begin
            state_d   = end_state_s;
            done_d    = last_trace_s;
            gap_cnt_d = '0;
          end else begin
            state_d   = ST_WAIT;
          end
        end else begin
          aes_en_d = 1'b1;
        end
      end
      ST_WAIT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (cap_now_s) begin
          state_d   = end_state_s;
          done_d    = last_trace_s;
          gap_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          state_d   = ST_WAIT;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_LAST) begin
          state_d    = ST_RUN;
          idx_d      = idx_q + IDX_W'(1);
          pt_d       = next_pt(pt_q);
          en_cnt_d   = '0;
          to_cnt_d   = '0;
          captured_d = 1'b0;
          aes_en_d   = 1'b1;
        end else begin
          state_d    = ST_GAP;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        aes_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.aes_en      = aes_en_q;
  assign bus.trig        = aes_en_q;
  assign bus.aes_data_in = pt_q;
  assign bus.aes_key_in  = key_q;
  assign bus.ct_valid    = ct_valid_q;
  assign bus.ct_data     = ct_data_q;
  assign bus.ct_index    = ct_index_q;
  assign bus.seq_busy    = busy_q;
  assign bus.seq_done    = done_q;
  assign bus.seq_timeout = timeout_q;
endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Bench for aes_trace_sequencer: stand-in AES responder with per-trace reply delays,
// an output monitor, and a timeline model built from edge arithmetic.
module tb_aes_trace_sequencer;
  localparam int NT   = 3;
  localparam int EN   = 51;
  localparam int GAP  = 15;
  localparam int TO   = 100;
  localparam int IW   = 16;
  localparam int GAPL = (GAP > 0) ? GAP : 1;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;
  int   campaign_id;
  int   delay_q [NT];
  bit   dup_en;
  int   stab_err;

  int           rise_q[$];
  logic [127:0] pin_q[$];
  int           fall_q[$];
  int           cedge_q[$];
  logic [127:0] cdata_q[$];
  int           cidx_q[$];
  int           done_q[$];
  int           bfall_q[$];

  aes_trace_sequencer_if #(.IDX_W(IW)) ifc ();

  aes_trace_sequencer #(
    .NUM_TRACES(NT), .EN_CYCLES(EN), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TO), .IDX_W(IW)
  ) dut (
    .AES_clk(clk),
    .AES_rst(rst),
    .bus(ifc.master)
  );

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stand-in cipher: any fixed bijection of (pt, key) is enough to tell traces apart.
  function automatic logic [127:0] ct_fn(input logic [127:0] p, input logic [127:0] k);
    return p ^ {k[63:0], k[127:64]} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  function automatic logic [127:0] model_next(input logic [127:0] p);
`ifdef AES_TRACE_LFSR_EN
    logic [127:0] r;
    r = p << 1;
    if (p[127]) r = r ^ 128'h87;
    return r;
`else
    return p + 128'd1;
`endif
  endfunction

  function automatic logic [127:0] model_seed(input logic [127:0] s);
`ifdef AES_TRACE_LFSR_EN
    return (s == 128'd0) ? 128'd1 : s;
`else
    return s;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ":aes_en"},      128'(ifc.aes_en),      128'd0);
    chk({tag, ":trig"},        128'(ifc.trig),        128'd0);
    chk({tag, ":ct_valid"},    128'(ifc.ct_valid),    128'd0);
    chk({tag, ":seq_busy"},    128'(ifc.seq_busy),    128'd0);
    chk({tag, ":seq_done"},    128'(ifc.seq_done),    128'd0);
    chk({tag, ":seq_timeout"}, 128'(ifc.seq_timeout), 128'd0);
    chk({tag, ":aes_data_in"}, ifc.aes_data_in,       128'd0);
    chk({tag, ":aes_key_in"},  ifc.aes_key_in,        128'd0);
    chk({tag, ":ct_data"},     ifc.ct_data,           128'd0);
    chk({tag, ":ct_index"},    128'(ifc.ct_index),    128'd0);
  endtask

  task automatic run_campaign(input string name, input logic [127:0] key,
                              input logic [127:0] seed, input int extra_at);
    int rb, fb, cb, db, bb, s0, n, s, e, d, exp_n, exp_cap, exp_done;
    bit finished, exp_to;
    int exp_rise [NT];
    logic [127:0] exp_pt [NT];
    int exp_cedge [NT];
    logic [127:0] exp_ct [NT];
    int exp_cidx [NT];
    logic [127:0] pt;

    rb = rise_q.size(); fb = fall_q.size(); cb = cedge_q.size();
    db = done_q.size(); bb = bfall_q.size();
    campaign_id++;
    @(negedge clk);
    ifc.seq_key = key; ifc.seq_seed = seed; ifc.seq_start = 1'b1;
    s0 = cyc + 1;
    @(negedge clk);
    ifc.seq_start = 1'b0; ifc.seq_key = rnd128(); ifc.seq_seed = rnd128();
    chk({name, ":busy_after_start"}, 128'(ifc.seq_busy), 128'd1);
    chk({name, ":key_in"}, ifc.aes_key_in, key);
    chk({name, ":timeout_cleared"}, 128'(ifc.seq_timeout), 128'd0);

    finished = 1'b0; n = 0;
    while (!finished && n < 5000) begin
      @(negedge clk);
      n++;
      ifc.seq_start = (n == extra_at);
      if (ifc.seq_done) finished = 1'b1;
    end
    ifc.seq_start = 1'b0;
    #1;
    chki({name, ":done_within_bound"}, int'(finished), 1);

    // Timeline model: trace t starts at edge s; reply at s+d; ends at max(s+EN, s+d).
    s = s0; pt = model_seed(seed); exp_n = 0; exp_cap = 0; exp_to = 1'b0; exp_done = 0;
    for (int t = 0; t < NT; t++) begin
      exp_rise[t] = s; exp_pt[t] = pt; exp_n++;
      d = delay_q[t];
      if (d >= 1 && d <= TO) begin
        exp_cedge[exp_cap] = s + d;
        exp_ct[exp_cap]    = ct_fn(pt, key);
        exp_cidx[exp_cap]  = t;
        exp_cap++;
        e = (d > EN) ? s + d : s + EN;
        exp_done = e;
        s  = e + GAPL;
        pt = model_next(pt);
      end else begin
        exp_to = 1'b1;
        exp_done = s + TO;
        break;
      end
    end

    chki({name, ":n_traces"},   rise_q.size() - rb,  exp_n);
    chki({name, ":n_en_falls"}, fall_q.size() - fb,  exp_n);
    chki({name, ":n_captures"}, cedge_q.size() - cb, exp_cap);
    for (int i = 0; i < exp_n && rb + i < rise_q.size(); i++) begin
      chki({name, ":en_rise_edge"}, rise_q[rb + i], exp_rise[i]);
      chk({name, ":aes_data_in"}, pin_q[rb + i], exp_pt[i]);
      if (fb + i < fall_q.size())
        chki({name, ":en_fall_edge"}, fall_q[fb + i], exp_rise[i] + EN);
    end
    for (int i = 0; i < exp_cap && cb + i < cedge_q.size(); i++) begin
      chki({name, ":ct_valid_edge"}, cedge_q[cb + i], exp_cedge[i]);
      chk({name, ":ct_data"}, cdata_q[cb + i], exp_ct[i]);
      chki({name, ":ct_index"}, cidx_q[cb + i], exp_cidx[i]);
    end
    chki({name, ":n_done"}, done_q.size() - db, 1);
    if (done_q.size() > db) chki({name, ":done_edge"}, done_q[db], exp_done);
    if (bfall_q.size() > bb) chki({name, ":busy_fall_edge"}, bfall_q[bb], exp_done);
    chk({name, ":timeout_flag"}, 128'(ifc.seq_timeout), 128'(exp_to));
    chk({name, ":busy_at_end"}, 128'(ifc.seq_busy), 128'd0);
    chk({name, ":key_held"}, ifc.aes_key_in, key);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // AES stand-in: replies delay_q[t] edges after the t-th enable rise (0 = never).
  initial begin : responder
    int rel, rt, seen_id, d;
    bit prev_en, fire;
    rel = 0; rt = -1; seen_id = 0; prev_en = 1'b0;
    ifc.aes_data_out_valid = 1'b0;
    ifc.aes_data_out = 128'd0;
    forever begin
      @(negedge clk);
      if (campaign_id != seen_id) begin
        seen_id = campaign_id;
        rt = -1;
      end
      if (ifc.aes_en && !prev_en) begin
        rt++;
        rel = 0;
      end else begin
        rel++;
      end
      prev_en = ifc.aes_en;
      d = (rt >= 0 && rt < NT) ? delay_q[rt] : 0;
      fire = (d > 0) && ((rel + 1 == d) || (dup_en && rel == d));
      ifc.aes_data_out_valid = fire;
      ifc.aes_data_out = fire ? ct_fn(ifc.aes_data_in, ifc.aes_key_in) : rnd128();
    end
  end

  initial begin : monitor
    bit m_prev_en, m_prev_busy;
    logic [127:0] m_prev_pin;
    m_prev_en = 1'b0; m_prev_busy = 1'b0; m_prev_pin = 128'd0; stab_err = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ifc.aes_en && !m_prev_en) begin
          rise_q.push_back(cyc);
          pin_q.push_back(ifc.aes_data_in);
        end else if (ifc.aes_data_in !== m_prev_pin) begin
          stab_err++;
        end
        if (!ifc.aes_en && m_prev_en) fall_q.push_back(cyc);
        if (ifc.ct_valid) begin
          cedge_q.push_back(cyc);
          cdata_q.push_back(ifc.ct_data);
          cidx_q.push_back(int'(ifc.ct_index));
        end
        if (ifc.seq_done) done_q.push_back(cyc);
        if (!ifc.seq_busy && m_prev_busy) bfall_q.push_back(cyc);
      end
      m_prev_en = ifc.aes_en;
      m_prev_busy = ifc.seq_busy;
      m_prev_pin = ifc.aes_data_in;
    end
  end

  initial begin : main
    int db;
    errors = 0; checks = 0; campaign_id = 0; dup_en = 1'b0;
    foreach (delay_q[i]) delay_q[i] = 0;
    rst = 1'b1;
    ifc.seq_start = 1'b0; ifc.seq_key = 128'd0; ifc.seq_seed = 128'd0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    delay_q = '{20, 51, 70};
    run_campaign("basic", 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc,
                 128'h000000a6_00000000_00000000_00000000, 0);

    dup_en = 1'b1;
    delay_q = '{60, 60, 60};
    run_campaign("late_dup", rnd128(), rnd128(), 0);
    dup_en = 1'b0;

    delay_q = '{5, 0, 0};
    run_campaign("timeout", rnd128(), rnd128(), 0);

    delay_q = '{10, 75, 33};
    run_campaign("wrap_start_busy", rnd128(), {128{1'b1}}, 30);

    // Asynchronous reset twenty cycles into the first enable window
    delay_q = '{200, 200, 200};
    campaign_id++;
    @(negedge clk);
    ifc.seq_key = rnd128(); ifc.seq_seed = rnd128(); ifc.seq_start = 1'b1;
    @(negedge clk);
    ifc.seq_start = 1'b0;
    db = done_q.size();
    repeat (19) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_zero("async_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1 chki("reset_no_done", done_q.size() - db, 0);

    delay_q = '{15, 45, 90};
    run_campaign("after_reset", rnd128(), rnd128(), 0);

    for (int k = 0; k < 4; k++) begin
      foreach (delay_q[i])
        delay_q[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 99));
      run_campaign("random", rnd128(), rnd128(), int'($urandom_range(0, 60)));
    end

    chki("data_in_stability", stab_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
